// File: rtl/rfid_rx_pkg.sv
// Shared definitions for the RFID receive-side sequencing blocks:
// the state encodings, the datapath widths and the window-length helpers.
package rfid_rx_pkg;

    localparam int SPEED_W = 3;
    localparam int CNT_W   = 18;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_GUARD   = 3'd1,
        ST_LISTEN  = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_HOLD    = 3'd4
    } rx_state_e;

    // Guard length is the base length scaled down by the BLF speed code.
    // The result is clamped to one cycle, because a zero load would never expire
    // and would leave the sequencer stuck in GUARD.
    function automatic logic [CNT_W-1:0] guard_len(input logic [31:0]        base,
                                                   input logic [SPEED_W-1:0] speed);
        logic [31:0] g;
        g = base >> speed;
        if (g == 32'd0) begin
            g = 32'd1;
        end
        return CNT_W'(g);
    endfunction

    // The listen timeout is four guard lengths, plus one more when the tag
    // sends the extended preamble.
    function automatic logic [CNT_W-1:0] timeout_len(input logic [CNT_W-1:0] g,
                                                     input logic             trext);
        logic [CNT_W+2:0] t;
        t = {3'b000, g} << 2;
        if (trext) begin
            t = t + {3'b000, g};
        end
        return CNT_W'(t);
    endfunction

endpackage

// File: rtl/rx_seq_timer.sv
// Down-counter for the receive sequencer. A load sets the count to N, and
// expire_o is high in the Nth cycle after the load. A load value of zero leaves
// the counter idle.
module rx_seq_timer
    import rfid_rx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load takes priority. Otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rx_seq_ctrl.sv
// Receive-window sequencer. After the reader finishes a frame, it waits out the
// guard time, listens for tag power, then keeps the receive datapath enabled
// until the decoder reports a frame or a window limit runs out. It then settles
// in HOLD for a short time before it goes back to IDLE.
module rx_seq_ctrl
    import rfid_rx_pkg::*;
#(
    parameter int unsigned GUARD_BASE = 4096,
    parameter int unsigned RX_MAX     = 200000,
    parameter int unsigned HOLD_CYC   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               tx_done_i,
    input  logic               abort_i,
    input  logic [SPEED_W-1:0] set_speed_i,
    input  logic               set_trext_i,
    input  logic [1:0]         de_mode_i,
    input  logic               sig_detect_i,
    input  logic               decode_done_i,
    output logic               sample_enable_o,
    output logic               rx_enable_o,
    output logic [SPEED_W-1:0] set_speed_o,
    output logic               set_trext_o,
    output logic [1:0]         de_mode_o,
    output logic               rx_done_o,
    output logic               rx_timeout_o,
    output logic               rx_overrun_o,
    output logic               tx_collide_o,
    output logic               busy_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] RX_MAX_L   = CNT_W'(RX_MAX);
    localparam logic [CNT_W-1:0] HOLD_CYC_L = CNT_W'(HOLD_CYC);

    rx_state_e          state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               trext_q, trext_d;
    logic [1:0]         mode_q, mode_d;
    logic               rx_en_q, rx_en_d;
    logic               smp_en_q, smp_en_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               collide_q, collide_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expire;

    rx_seq_timer u_timer (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Next state, timer loads, config latch and status pulses. Abort overrides everything.
    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        trext_d   = trext_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        collide_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            if (tx_done_i && (state_q != ST_IDLE)) begin
                collide_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tx_done_i) begin
                        speed_d  = set_speed_i;
                        trext_d  = set_trext_i;
                        mode_d   = de_mode_i;
                        tmr_load = 1'b1;
                        tmr_val  = guard_len(32'(GUARD_BASE), set_speed_i);
                        state_d  = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (tmr_expire) begin
                        tmr_load = 1'b1;
                        tmr_val  = timeout_len(guard_len(32'(GUARD_BASE), speed_q), trext_q);
                        state_d  = ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    if (sig_detect_i) begin
                        tmr_load = 1'b1;
                        tmr_val  = RX_MAX_L;
                        state_d  = ST_RECEIVE;
                    end else if (tmr_expire) begin
                        timeout_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = HOLD_CYC_L;
                        state_d   = ST_HOLD;
                    end
                end
                ST_RECEIVE: begin
                    if (decode_done_i) begin
                        done_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_CYC_L;
                        state_d  = ST_HOLD;
                    end else if (tmr_expire) begin
                        overrun_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = HOLD_CYC_L;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_expire) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Enables follow the state one cycle later. An abort clears them at the same edge that forces IDLE.
    always_comb begin
        rx_en_d  = 1'b0;
        smp_en_d = 1'b0;
        if (!abort_i) begin
            rx_en_d  = (state_q == ST_LISTEN) || (state_q == ST_RECEIVE);
            smp_en_d = (state_q == ST_GUARD) || (state_q == ST_LISTEN) ||
                       (state_q == ST_RECEIVE);
        end
    end

    // State, configuration, enable and pulse registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            speed_q   <= '0;
            trext_q   <= 1'b0;
            mode_q    <= '0;
            rx_en_q   <= 1'b0;
            smp_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            trext_q   <= trext_d;
            mode_q    <= mode_d;
            rx_en_q   <= rx_en_d;
            smp_en_q  <= smp_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            collide_q <= collide_d;
        end
    end

    assign sample_enable_o = smp_en_q;
    assign rx_enable_o     = rx_en_q;
    assign set_speed_o     = speed_q;
    assign set_trext_o     = trext_q;
    assign de_mode_o       = mode_q;
    assign rx_done_o       = done_q;
    assign rx_timeout_o    = timeout_q;
    assign rx_overrun_o    = overrun_q;
    assign tx_collide_o    = collide_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign state_o         = state_q;

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Directed bench for rx_seq_ctrl. Inputs change and outputs are sampled on the
// falling clock edge. The RX_MAX window is shortened so the overrun boundary
// can be reached quickly.
module tb_rx_seq_ctrl;

   localparam int GuardBase = 4096;
   localparam int RxMax     = 300;
   localparam int HoldCyc   = 8;
   localparam int WaitLimit = 6000;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StGuard   = 3'd1;
   localparam logic [2:0] StListen  = 3'd2;
   localparam logic [2:0] StReceive = 3'd3;
   localparam logic [2:0] StHold    = 3'd4;

   logic       clk = 1'b0;
   logic       rstN;
   logic       txDone, abortIn, setTrext, sigDetect, decodeDone;
   logic [2:0] setSpeed;
   logic [1:0] deMode;
   logic       sampleEnable, rxEnable, trextOut, rxDone, rxTimeout, rxOverrun, txCollide, busy;
   logic [2:0] speedOut, stateOut;
   logic [1:0] modeOut;

   int checks = 0;
   int failures = 0;
   int doneCnt = 0;
   int timeoutCnt = 0;
   int overrunCnt = 0;
   int collideCnt = 0;
   int n;

   rx_seq_ctrl #(
      .GUARD_BASE (GuardBase),
      .RX_MAX     (RxMax),
      .HOLD_CYC   (HoldCyc)
   ) dut (
      .clk_i           (clk),
      .rst_n           (rstN),
      .tx_done_i       (txDone),
      .abort_i         (abortIn),
      .set_speed_i     (setSpeed),
      .set_trext_i     (setTrext),
      .de_mode_i       (deMode),
      .sig_detect_i    (sigDetect),
      .decode_done_i   (decodeDone),
      .sample_enable_o (sampleEnable),
      .rx_enable_o     (rxEnable),
      .set_speed_o     (speedOut),
      .set_trext_o     (trextOut),
      .de_mode_o       (modeOut),
      .rx_done_o       (rxDone),
      .rx_timeout_o    (rxTimeout),
      .rx_overrun_o    (rxOverrun),
      .tx_collide_o    (txCollide),
      .busy_o          (busy),
      .state_o         (stateOut)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Counts the cycles in which each status pulse is high, so that pulse widths and spurious pulses can be checked.
   always @(negedge clk) begin
      if (rxDone === 1'b1) doneCnt++;
      if (rxTimeout === 1'b1) timeoutCnt++;
      if (rxOverrun === 1'b1) overrunCnt++;
      if (txCollide === 1'b1) collideCnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic tx, input logic ab, input logic det, input logic dec);
      txDone     = tx;
      abortIn    = ab;
      sigDetect  = det;
      decodeDone = dec;
   endtask

   task automatic setConfig(input logic [2:0] sp, input logic tr, input logic [1:0] md);
      setSpeed = sp;
      setTrext = tr;
      deMode   = md;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Counts the cycles spent in state st, starting from the cycle currently observed. The count is bounded by WaitLimit.
   task automatic countState(input logic [2:0] st, output int cnt);
      cnt = 0;
      while (stateOut === st && cnt < WaitLimit) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      rstN = 1'b0;
      setConfig(3'd5, 1'b1, 2'd3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      $display("[TB] reset state");
      checkOutput("rst_state", stateOut, StIdle);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_enables", {sampleEnable, rxEnable}, 0);
      checkOutput("rst_config", {speedOut, trextOut, modeOut}, 0);
      checkOutput("rst_pulses", {rxDone, rxTimeout, rxOverrun, txCollide}, 0);
      tick();
      rstN = 1'b1;
      tick();
      tick();
      checkOutput("idle_no_txdone", stateOut, StIdle);

      // Test A: speed 3, no trext. Detect is held high during GUARD and must be ignored.
      // A detect in LISTEN cycle 10 must then move the sequencer to RECEIVE.
      $display("[TB] normal receive sequence");
      setConfig(3'd3, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      setConfig(3'd0, 1'b1, 2'd0);
      checkOutput("a_guard_entry", stateOut, StGuard);
      checkOutput("a_busy", busy, 1);
      checkOutput("a_cfg_speed", speedOut, 3);
      checkOutput("a_cfg_trext", trextOut, 0);
      checkOutput("a_cfg_mode", modeOut, 2);
      checkOutput("a_smp_lag", sampleEnable, 0);
      tick();
      checkOutput("a_smp_on", sampleEnable, 1);
      countState(StGuard, n);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("a_guard_len", n + 1, 512);
      checkOutput("a_listen", stateOut, StListen);
      checkOutput("a_rxen_lag", rxEnable, 0);
      tick();
      checkOutput("a_rxen_on", rxEnable, 1);
      repeat (8) tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("a_receive", stateOut, StReceive);
      repeat (3) tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("a_hold", stateOut, StHold);
      checkOutput("a_rx_done", rxDone, 1);
      countState(StHold, n);
      checkOutput("a_hold_len", n, HoldCyc);
      checkOutput("a_idle", stateOut, StIdle);
      checkOutput("a_enables_off", {sampleEnable, rxEnable}, 0);
      checkOutput("a_pulses", {doneCnt, timeoutCnt, overrunCnt}, {32'd1, 32'd0, 32'd0});

      // Test B: speed 3 with trext and no detect. The timeout must come after 2560 LISTEN cycles.
      $display("[TB] listen timeout");
      setConfig(3'd3, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StGuard, n);
      checkOutput("b_guard_len", n, 512);
      countState(StListen, n);
      checkOutput("b_listen_len", n, 2560);
      checkOutput("b_hold", stateOut, StHold);
      checkOutput("b_timeout_pulse", rxTimeout, 1);
      countState(StHold, n);
      checkOutput("b_hold_len", n, HoldCyc);
      checkOutput("b_idle", stateOut, StIdle);
      checkOutput("b_pulses", {doneCnt, timeoutCnt, overrunCnt}, {32'd1, 32'd1, 32'd0});

      // Test C: speed 7 gives G=32 and T=128. Detect in the last LISTEN cycle must win over the timeout.
      // decode_done in the last RECEIVE cycle must win over the overrun.
      $display("[TB] coincidence boundaries");
      setConfig(3'd7, 1'b0, 2'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StGuard, n);
      checkOutput("c_guard_len", n, 32);
      repeat (127) tick();
      checkOutput("c_listen_last", stateOut, StListen);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("c_detect_wins", stateOut, StReceive);
      repeat (299) tick();
      checkOutput("c_receive_last", stateOut, StReceive);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("c_hold", stateOut, StHold);
      checkOutput("c_done_wins", {rxDone, rxOverrun}, 2'b10);
      countState(StHold, n);
      checkOutput("c_pulses", {doneCnt, timeoutCnt, overrunCnt}, {32'd2, 32'd1, 32'd0});

      // Test C2: no decode_done. RECEIVE must run for RX_MAX cycles and then report an overrun.
      $display("[TB] receive overrun");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StGuard, n);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StReceive, n);
      checkOutput("c2_receive_len", n, RxMax);
      checkOutput("c2_overrun_pulse", rxOverrun, 1);
      countState(StHold, n);
      checkOutput("c2_pulses", {doneCnt, timeoutCnt, overrunCnt}, {32'd2, 32'd1, 32'd1});

      // Test D: tx_done during LISTEN raises a collision and leaves state and config untouched.
      // Test E: abort in RECEIVE then drops to IDLE with no status pulse.
      $display("[TB] collision and abort");
      setConfig(3'd7, 1'b0, 2'd3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StGuard, n);
      repeat (2) tick();
      setConfig(3'd0, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("d_state_kept", stateOut, StListen);
      checkOutput("d_collide", txCollide, 1);
      checkOutput("d_cfg_kept", {speedOut, trextOut, modeOut}, {3'd7, 1'b0, 2'd3});
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("e_receive", stateOut, StReceive);
      checkOutput("e_rxen_on", rxEnable, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("e_abort_idle", stateOut, StIdle);
      checkOutput("e_abort_enables", {sampleEnable, rxEnable}, 0);
      checkOutput("e_abort_busy", busy, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("e_txdone_abort_ignored", stateOut, StIdle);
      repeat (3) tick();
      checkOutput("e_pulses", {doneCnt, timeoutCnt, overrunCnt, collideCnt},
                  {32'd2, 32'd1, 32'd1, 32'd1});

      // Test F: reset asserted mid-window clears every output at once, and the block then waits in IDLE.
      $display("[TB] reset during listen");
      setConfig(3'd7, 1'b1, 2'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      countState(StGuard, n);
      repeat (3) tick();
      checkOutput("f_listen_enabled", {stateOut, rxEnable}, {StListen, 1'b1});
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("f_rst_state", stateOut, StIdle);
      checkOutput("f_rst_enables", {sampleEnable, rxEnable, busy}, 0);
      checkOutput("f_rst_config", {speedOut, trextOut, modeOut}, 0);
      tick();
      rstN = 1'b1;
      repeat (5) tick();
      checkOutput("f_stays_idle", stateOut, StIdle);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("f_restart_guard", stateOut, StGuard);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_seq_ctrl.md
RX_SEQ_CTRL -- requirements
Module: rx_seq_ctrl

Interface
REQ-001 SHALL have parameter GUARD_BASE, 4096, T1 guard cycles at set_speed 0 (range 32..65535).
REQ-002 SHALL have parameter RX_MAX, 200000, maximum RECEIVE duration in cycles.
REQ-003 SHALL have parameter HOLD_CYC, 8, post-receive settle cycles (range 1..255).
REQ-004 SHALL have port clk_i  in  1  clock; reset rst_n, asynchronous, active-low.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port tx_done_i  in  1  single-cycle pulse: reader TX frame finished.
REQ-007 SHALL have port abort_i  in  1  level/pulse: cancel the receive window.
REQ-008 SHALL have port set_speed_i  in  3  BLF speed code.
REQ-009 SHALL have port set_trext_i  in  1  extended-preamble flag.
REQ-010 SHALL have port de_mode_i  in  2  decode mode (FM0/Miller).
REQ-011 SHALL have port sig_detect_i  in  1  tag-power detect from the IQ power detector.
REQ-012 SHALL have port decode_done_i  in  1  single-cycle pulse: decoder frame complete.
REQ-013 SHALL have ports sample_enable_o, rx_enable_o  out  1 each  datapath enables.
REQ-014 SHALL have ports set_speed_o 3, set_trext_o 1, de_mode_o 2  out  latched configuration.
REQ-015 SHALL have ports rx_done_o, rx_timeout_o, rx_overrun_o, tx_collide_o  out  1 each  single-cycle status pulses.
REQ-016 SHALL have ports busy_o  out  1, and state_o  out  3  current state code.

Function
REQ-017 SHALL implement states IDLE=0, GUARD=1, LISTEN=2, RECEIVE=3, HOLD=4; other codes SHALL return to IDLE.
REQ-018 In IDLE, tx_done_i SHALL latch set_speed_i, set_trext_i, de_mode_i into the *_o configuration outputs, load the counter, and enter GUARD next cycle.
REQ-019 Guard length G SHALL be GUARD_BASE >> set_speed (latched value); timeout T SHALL be 4*G, plus G when trext is latched; counter width SHALL be 18 bits, unsigned.
REQ-020 GUARD SHALL last exactly G cycles and then enter LISTEN; sig_detect_i is ignored during GUARD.
REQ-021 LISTEN SHALL enter RECEIVE on the first cycle with sig_detect_i=1; after T LISTEN cycles without detect it SHALL pulse rx_timeout_o and enter HOLD.
REQ-022 If detect and timeout expiry coincide, detect SHALL win.
REQ-023 RECEIVE SHALL enter HOLD and pulse rx_done_o on decode_done_i; after RX_MAX cycles it SHALL pulse rx_overrun_o and enter HOLD; on coincidence decode_done_i SHALL win.
REQ-024 HOLD SHALL last HOLD_CYC cycles, then return to IDLE.
REQ-025 rx_enable_o SHALL be 1 in LISTEN and RECEIVE only; sample_enable_o SHALL be 1 in GUARD, LISTEN and RECEIVE; both outputs SHALL be registered and change in the cycle after the state change.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 abort_i=1 SHALL force IDLE in the next cycle from any state, SHALL drop both enables, SHALL emit no status pulse, and SHALL take priority over all other events.
REQ-028 tx_done_i outside IDLE SHALL be ignored and SHALL pulse tx_collide_o; tx_done_i coinciding with abort_i SHALL be ignored.
REQ-029 Latched configuration SHALL be held stable from the latch until the next accepted tx_done_i.

Reset
REQ-030 On rst_n=0, the block SHALL enter IDLE and all outputs SHALL go to 0, including the configuration outputs and state_o.
REQ-031 Reset assertion mid-window SHALL drop the enables asynchronously; the block SHALL stay in IDLE after release until a tx_done_i arrives.

Structure
REQ-032 State encodings, the speed-code width and the counter width SHALL reside in the shared package rfid_rx_pkg.
REQ-033 The counter SHALL be one sub-module, rx_seq_timer: load value and load strobe in, a single-cycle expire pulse out.

Verification
REQ-034 Sequence: GUARD_BASE=4096, speed=3, trext=0; tx_done, then sig_detect in LISTEN cycle 10 -> GUARD 512 cycles, RECEIVE entered in the cycle after the detect.
REQ-035 Timeout: speed=3, trext=1, no detect -> rx_timeout_o pulses after 2560 LISTEN cycles, then HOLD 8 cycles, then IDLE.
REQ-036 Coincidence: sig_detect asserted in the final LISTEN cycle -> RECEIVE, no timeout pulse; decode_done in RX_MAX cycle -> rx_done_o only.
REQ-037 Abort in RECEIVE -> IDLE the next cycle, enables 0, no rx_done/timeout/overrun pulse.
REQ-038 tx_done in LISTEN -> tx_collide_o pulse, state and configuration unchanged.
REQ-039 rst_n low during LISTEN -> all outputs 0 immediately; the block stays IDLE after release.
